myproject_acc_requant_43_16: RTL

MYPROJECT_ACC_REQUANT_43_16 -- requirements
Module: myproject_acc_requant_43_16

---
 rtl/myproject_acc_requant_43_16.sv | 62 ++++++
 1 files changed

// File: rtl/myproject_acc_requant_43_16.sv
// myproject_acc_requant_43_16: sums N_TERMS signed products, rounds, shifts and saturates to OUT_W
module myproject_acc_requant_43_16 #(
    parameter int N_TERMS = 8,
    parameter int IN_W    = 43,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 10
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int ACC_W = IN_W + $clog2(N_TERMS);
    localparam int CW    = $clog2(N_TERMS);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);

    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc, ext, sum;
    logic signed [ACC_W:0]   rnd, r;
    logic                    last, fire, done, hi, lo;

    assign last     = cnt == CW'(N_TERMS-1);
    assign in_ready = !(out_valid && !out_ready && last);
    assign fire     = in_valid && in_ready;
    assign done     = fire && last;
    assign ext      = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign sum      = acc + ext;
    // one extra bit so the rounding offset can never wrap the sum
    assign rnd      = {sum[ACC_W-1], sum} + HALF;
    assign r        = rnd >>> SHIFT;
    assign hi       = r > MAXV;
    assign lo       = r < MINV;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (fire) begin
                cnt <= last ? '0 : cnt + CW'(1);
                acc <= cnt == '0 ? ext : sum;
            end
            if (done) begin
                out_valid <= 1'b1;
                out_data  <= hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
                out_sat   <= hi || lo;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
